// File: rtl/pcr_pkg.sv
// Shared definitions for the PCR port arbiter: default widths,
// requester index encoding and the access-sequencer state encoding.
package pcr_pkg;

    localparam int PCR_ADDR_W = 5;
    localparam int PCR_DATA_W = 64;

    // Requester indices; also the encoding of the round-robin "last winner".
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } pcr_state_e;

endpackage

// File: rtl/pcr_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time (rr_last_i) gets the grant.
module rr_arb2
    import pcr_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       rr_last_i,
    output logic [1:0] grant_o
);

    // One-hot grant; index 0 is preferred on a tie only if index 1 won last.
    always_comb begin
        grant_o = 2'b00;
        if (valid0_i && (!valid1_i || rr_last_i == REQ_HOST)) begin
            grant_o[0] = 1'b1;
        end else if (valid1_i) begin
            grant_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/pcr_port_arbiter.sv
// Shares the single PCR read/write port between the core and the host/debug
// interface. One request is in flight at a time; the access is sequenced
// through ISSUE (one strobe), WAIT (read latency) and RESP (hold response).
module pcr_port_arbiter
    import pcr_pkg::*;
#(
    parameter int ADDR_W = PCR_ADDR_W,
    parameter int DATA_W = PCR_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_wr,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_resp_valid,
    input  logic              core_resp_ready,
    output logic [DATA_W-1:0] core_resp_rdata,

    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_wr,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_resp_valid,
    input  logic              host_resp_ready,
    output logic [DATA_W-1:0] host_resp_rdata,

    output logic              pcr_en,
    output logic              pcr_wen,
    output logic [ADDR_W-1:0] pcr_addr,
    output logic [DATA_W-1:0] pcr_wdata,
    input  logic [DATA_W-1:0] pcr_rdata
);

    // Counter value loaded in ISSUE so that WAIT lasts exactly RD_LAT cycles.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    pcr_state_e        state_q;
    logic              rr_last_q;
    logic              owner_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [1:0]        wait_cnt_q;
    logic              pcr_en_q;
    logic              pcr_wen_q;
    logic              core_resp_valid_q;
    logic              host_resp_valid_q;

    logic [1:0]        grant;
    logic              accept_en;
    logic              core_hs;
    logic              host_hs;
    logic              resp_hs;
    logic              owner_d;
    logic              wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    rr_arb2 u_rr_arb2 (
        .valid0_i  (core_req_valid),
        .valid1_i  (host_req_valid),
        .rr_last_i (rr_last_q),
        .grant_o   (grant)
    );

    // Readies are combinational from the grant, but only while idle and out of reset.
    assign accept_en      = !reset && (state_q == IDLE);
    assign core_req_ready = accept_en && grant[0];
    assign host_req_ready = accept_en && grant[1];
    assign core_hs        = core_req_valid && core_req_ready;
    assign host_hs        = host_req_valid && host_req_ready;
    assign resp_hs        = (core_resp_valid_q && core_resp_ready) ||
                            (host_resp_valid_q && host_resp_ready);

    // Request fields of whichever requester is handshaking this cycle.
    always_comb begin
        owner_d = REQ_CORE;
        wr_d    = core_req_wr;
        addr_d  = core_req_addr;
        wdata_d = core_req_wdata;
        if (host_hs) begin
            owner_d = REQ_HOST;
            wr_d    = host_req_wr;
            addr_d  = host_req_addr;
            wdata_d = host_req_wdata;
        end
    end

    // Access sequencer with registered PCR strobes and response valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            rr_last_q         <= REQ_HOST;
            owner_q           <= REQ_CORE;
            wr_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            resp_data_q       <= '0;
            wait_cnt_q        <= '0;
            pcr_en_q          <= 1'b0;
            pcr_wen_q         <= 1'b0;
            core_resp_valid_q <= 1'b0;
            host_resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_hs || host_hs) begin
                        owner_q   <= owner_d;
                        rr_last_q <= owner_d;
                        wr_q      <= wr_d;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                        pcr_en_q  <= 1'b1;
                        pcr_wen_q <= wr_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    pcr_en_q  <= 1'b0;
                    pcr_wen_q <= 1'b0;
                    if (wr_q) begin
                        resp_data_q       <= '0;
                        core_resp_valid_q <= (owner_q == REQ_CORE);
                        host_resp_valid_q <= (owner_q == REQ_HOST);
                        state_q           <= RESP;
                    end else begin
                        wait_cnt_q <= WAIT_INIT;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        resp_data_q       <= pcr_rdata;
                        core_resp_valid_q <= (owner_q == REQ_CORE);
                        host_resp_valid_q <= (owner_q == REQ_HOST);
                        state_q           <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        core_resp_valid_q <= 1'b0;
                        host_resp_valid_q <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pcr_en          = pcr_en_q;
    assign pcr_wen         = pcr_wen_q;
    assign pcr_addr        = addr_q;
    assign pcr_wdata       = wdata_q;
    assign core_resp_valid = core_resp_valid_q;
    assign host_resp_valid = host_resp_valid_q;
    assign core_resp_rdata = (owner_q == REQ_CORE) ? resp_data_q : '0;
    assign host_resp_rdata = (owner_q == REQ_HOST) ? resp_data_q : '0;

endmodule

// File: doc/pcr_port_arbiter.md
Name: pcr_port_arbiter

Overview:
- Shares the single read/write port of the processor control register (PCR) file between two requesters: the core (index 0) and the host/debug interface (index 1).
- Accepts one request at a time on a valid/ready handshake and arbitrates between requesters round-robin.
- Sequences the PCR port through issue, read-wait and response phases, then returns read data (or a write acknowledgement) to the winner.
- Sits between the core/host request paths and the PCR file.

Parameters:
- ADDR_W, 5, PCR address width.
- DATA_W, 64, PCR data width.
- RD_LAT, 1, PCR read latency in cycles (1..3).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req_valid  in  1  core request present.
- core_req_ready  out  1  core request accepted this cycle.
- core_req_wr  in  1  1 = write, 0 = read.
- core_req_addr  in  ADDR_W  PCR address.
- core_req_wdata  in  DATA_W  write data.
- core_resp_valid  out  1  core response present.
- core_resp_ready  in  1  core takes the response.
- core_resp_rdata  out  DATA_W  read data; 0 for writes.
- host_req_valid, host_req_ready, host_req_wr, host_req_addr, host_req_wdata  same directions and widths as the core_req_* ports, for the host.
- host_resp_valid, host_resp_ready, host_resp_rdata  same as the core_resp_* ports, for the host.
- pcr_en  out  1  PCR port access strobe.
- pcr_wen  out  1  PCR write enable; qualified by pcr_en.
- pcr_addr  out  ADDR_W  PCR address.
- pcr_wdata  out  DATA_W  PCR write data.
- pcr_rdata  in  DATA_W  PCR read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- State machine states: IDLE, ISSUE, WAIT, RESP.
- Reset: state = IDLE, rr_last = 1 (so core wins the first tie), wait counter = 0.
- Reset values of outputs: all *_ready, *_resp_valid, pcr_en and pcr_wen are 0; pcr_addr, pcr_wdata and *_resp_rdata are 0.
- Reset mid-operation: any in-flight access is abandoned and no response is produced. A PCR write already strobed is not undone.
- IDLE, arbitration:
  - If exactly one *_req_valid is high, that requester wins.
  - If both are high, the requester other than rr_last wins.
  - The winner's *_req_ready is driven high combinationally in the same cycle. The loser's ready stays 0.
  - On handshake, latch owner, wr, addr and wdata; set rr_last = owner; go to ISSUE.
  - Only one ready may be high in any cycle.
- ISSUE (exactly 1 cycle):
  - pcr_en = 1, pcr_wen = wr, pcr_addr and pcr_wdata from the latched values.
  - On a write, go to RESP with resp_data = 0.
  - On a read, load the wait counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture pcr_rdata into resp_data and go to RESP.
  - With RD_LAT = 1, WAIT lasts exactly 1 cycle.
- RESP:
  - Drive owner's *_resp_valid = 1 and *_resp_rdata = resp_data, held stable until *_resp_ready.
  - On handshake, go to IDLE.
  - No new request is accepted before that IDLE cycle.
- Latencies:
  - Minimum request-accept to resp_valid: 2 cycles for a write, 2+RD_LAT cycles for a read.
  - Minimum turnaround between back-to-back grants: write 3 cycles; read 3+RD_LAT cycles.
- pcr_en is high only in ISSUE, so each accepted request strobes the PCR port exactly once.
- The non-owner's resp_valid is always 0.
- A request dropped before its handshake is legal and leaves no state.

Decomposition:
- Shared package pcr_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The requester index encoding: CORE = 0, HOST = 1.
  - The state encoding enum: IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3.
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter (inputs: two valids, rr_last; outputs: one-hot grant). Everything else stays in pcr_port_arbiter.

Test Plan:
- Core read, addr 5'h03, PCR returns 64'hDEAD_BEEF, RD_LAT = 1 -> pcr_en pulses 1 cycle with wen = 0 and addr = 3; core_resp_valid 3 cycles after accept with rdata = 64'hDEAD_BEEF; host signals stay 0.
- Host write, addr 5'h1F, data 64'h0123_4567_89AB_CDEF -> a single pcr_en&pcr_wen cycle with that address and data; host_resp_valid with rdata = 0.
- Both valid continuously from reset, reads -> grants alternate core, host, core, host; never two readies in one cycle; each pcr_en matches its owner's address.
- Core response stalled (core_resp_ready = 0 for 5 cycles) while host_req_valid = 1 -> resp_valid and rdata held stable; host_req_ready stays 0 until one cycle after the core response handshake.
- RD_LAT = 3, read -> pcr_rdata is sampled exactly 3 cycles after the pcr_en cycle; a value change on pcr_rdata in other cycles does not affect resp_rdata.
- Reset asserted during WAIT -> next cycle state is IDLE; no resp_valid; the next request is granted to core on a tie.
